// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a serialiser, LSB first.
// Optional even-parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   tx_data,
  input  logic                         tx_data_valid,
  output logic                         tx_ready,
  output logic                         tx,
  output logic                         tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = $clog2(BAUD_DIV);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [PTR_W:0]   FULL      = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic               tx_q, tx_d;
  logic [7:0]         shift_q, shift_d;
  logic [PTR_W-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic               push, pop, baud_wrap;

  assign tx_ready   = rst_n && (count_q != FULL);
  assign push       = tx_data_valid && tx_ready;
  assign baud_wrap  = (cnt_q == BAUD_LAST);
  assign tx         = tx_q;
  assign tx_busy    = (state_q != IDLE);
  assign fifo_count = count_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    if (state_q != IDLE) cnt_d = baud_wrap ? '0 : cnt_q + CNT_W'(1);
    case (state_q)
      IDLE:  if (count_q != '0) pop = 1'b1;
      START: if (baud_wrap) begin
        state_d = DATA;
        idx_d   = 3'd0;
        tx_d    = shift_q[0];
      end
      DATA: if (baud_wrap) begin
        if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
          tx_d    = ^shift_q;
`else
          state_d = STOP;
          tx_d    = 1'b1;
`endif
        end else begin
          idx_d = idx_q + 3'd1;
          tx_d  = shift_q[idx_q + 3'd1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_wrap) begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
`endif
      STOP: if (baud_wrap) begin
        // Chain straight into the next frame so bursts leave no idle gap.
        if (count_q != '0) pop = 1'b1;
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      shift_d = mem_q[rd_q];
      tx_d    = 1'b0;
      state_d = START;
      cnt_d   = '0;
      idx_d   = 3'd0;
    end
  end

  always_comb begin
    rd_d    = pop  ? rd_q + PTR_W'(1) : rd_q;
    wr_d    = push ? wr_q + PTR_W'(1) : wr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      tx_q    <= 1'b1;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the control state.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (push) mem_q[wr_q] <= tx_data;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-timer reference model, line decoder and directed vectors.
module tb_uart_tx_fifo;
  localparam int BD    = 10;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int SLOTS = 11;
`else
  localparam int SLOTS = 10;
`endif
  localparam int FRAME = SLOTS * BD;

  logic       clk, rst_n, tx_data_valid, tx_ready, tx, tx_busy;
  logic [7:0] tx_data;
  logic [4:0] fifo_count;

  uart_tx_fifo #(.CLK_FREQ(1000), .BAUD_RATE(100), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .fifo_count(fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: queue of waiting bytes plus a timer into the current frame.
  logic [7:0] m_q[$];
  logic [7:0] acc_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] m_cur;
  logic       m_active = 1'b0;
  logic       model_ok = 1'b0;
  int         m_t = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_q.delete();
      m_active = 1'b0;
      m_t      = 0;
      model_ok = 1'b1;
    end else begin
      automatic bit rdy       = (m_q.size() != DEPTH);
      automatic bit end_frame = m_active && (m_t == FRAME - 1);
      if ((!m_active || end_frame) && m_q.size() != 0) begin
        m_cur    = m_q.pop_front();
        m_active = 1'b1;
        m_t      = 0;
      end else if (end_frame) m_active = 1'b0;
      else if (m_active) m_t++;
      if (tx_data_valid && rdy) begin
        m_q.push_back(tx_data);
        acc_q.push_back(tx_data);
      end
    end
  end

  function automatic logic exp_tx();
    int s;
    if (!m_active) return 1'b1;
    s = m_t / BD;
    if (s == 0) return 1'b0;
    if (s <= 8) return m_cur[s-1];
    if (SLOTS == 11 && s == 9) return ^m_cur;
    return 1'b1;
  endfunction

  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      check("tx", int'(tx), int'(exp_tx()));
      check("tx_busy", int'(tx_busy), int'(m_active));
      check("fifo_count", int'(fifo_count), m_q.size());
      check("tx_ready", int'(tx_ready), int'(rst_n && m_q.size() != DEPTH));
    end
  end

  // Line decoder: samples mid-bit from the first low level seen while idle.
  logic       rx_en = 1'b0;
  logic [7:0] rx_byte;
  initial begin
    wait (rx_en);
    forever begin
      @(negedge clk);
      if (tx == 1'b0) begin
        repeat (BD/2 - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          rx_byte[i] = tx;
        end
        repeat (BD * (SLOTS - 9)) @(negedge clk);
        rx_q.push_back(rx_byte);
      end
    end
  end

  initial begin
    int busy_cnt, low_cnt, n;
    logic [10:0] e55;
`ifdef UART_TX_PARITY_EN
    e55 = 11'b10010101010;
`else
    e55 = 11'b01010101010;
`endif
    // Reset held with valid asserted
    rst_n = 1'b0; tx_data_valid = 1'b1; tx_data = 8'hAA;
    tick(3);
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(tx_busy), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_ready", int'(tx_ready), 0);
    rst_n = 1'b1; tx_data_valid = 1'b0;
    tick(1);
    check("rel_ready", int'(tx_ready), 1);
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin tick(1); if (tx_busy || !tx) busy_cnt++; end
    check("rel_quiet", busy_cnt, 0);
    rx_en = 1'b1;

    // Single byte 0x55
    rx_q.delete();
    tx_data = 8'h55; tx_data_valid = 1'b1;
    check("single_pre_tx", int'(tx), 1);
    tick(1);
    tx_data_valid = 1'b0;
    busy_cnt = 0;
    for (int k = 1; k <= FRAME + 10; k++) begin
      tick(1);
      if (tx_busy) busy_cnt++;
      if (k == 1) check("single_start_edge", int'(tx), 0);
      if (k % BD == 5 && k / BD < SLOTS) check("single_slot", int'(tx), int'(e55[k/BD]));
    end
    check("single_busy_len", busy_cnt, FRAME);
    check("single_rx_n", rx_q.size(), 1);
    if (rx_q.size() > 0) check("single_rx_byte", int'(rx_q[0]), 8'h55);

    // Back-to-back 0xA3, 0x0F
    rx_q.delete();
    tx_data_valid = 1'b1; tx_data = 8'hA3; tick(1);
    tx_data = 8'h0F; tick(1);
    tx_data_valid = 1'b0;
    low_cnt = 0;
    for (int k = 2; k <= 2*FRAME + 15; k++) begin
      tick(1);
      if (k == FRAME) check("b2b_last_stop", int'(tx), 1);
      if (k == FRAME + 1) check("b2b_second_start", int'(tx), 0);
      if (k <= 2*FRAME && !tx_busy) low_cnt++;
    end
    check("b2b_no_idle", low_cnt, 0);
    check("b2b_rx_n", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("b2b_rx0", int'(rx_q[0]), 8'hA3);
      check("b2b_rx1", int'(rx_q[1]), 8'h0F);
    end

    // Fill with 0x00..0x13 while valid stays high
    rx_q.delete(); acc_q.delete();
    tx_data_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tx_data = 8'(i);
      tick(1);
      if (i == 1) begin
        check("fill_first_popped", int'(tx_busy), 1);
        check("fill_count_e2", int'(fifo_count), 1);
      end
      if (i == 15) check("fill_ready_15", int'(tx_ready), 1);
      if (i == 16) begin
        check("fill_count_full", int'(fifo_count), 16);
        check("fill_ready_full", int'(tx_ready), 0);
      end
    end
    tx_data_valid = 1'b0;
    check("fill_accepted_n", acc_q.size(), 17);
    n = 0;
    while ((m_active || m_q.size() != 0) && n < 3000) begin tick(1); n++; end
    check("fill_drain_in_time", int'(n < 3000), 1);
    tick(10);
    check("fill_rx_n", rx_q.size(), 17);
    for (int i = 0; i < 17 && i < rx_q.size() && i < acc_q.size(); i++) begin
      check("fill_rx_vs_accepted", int'(rx_q[i]), int'(acc_q[i]));
      check("fill_rx_byte", int'(rx_q[i]), i);
    end

`ifdef UART_TX_PARITY_EN
    tx_data = 8'h07; tx_data_valid = 1'b1; tick(1); tx_data_valid = 1'b0;
    tick(95);
    check("parity_07", int'(tx), 1);
    tick(30);
    tx_data = 8'h03; tx_data_valid = 1'b1; tick(1); tx_data_valid = 1'b0;
    tick(95);
    check("parity_03", int'(tx), 0);
    tick(30);
`endif

    // Reset during data bit 4 of 0xFF with three bytes queued
    tx_data_valid = 1'b1;
    tx_data = 8'hFF; tick(1);
    tx_data = 8'h01; tick(1);
    tx_data = 8'h02; tick(1);
    tx_data = 8'h03; tick(1);
    tx_data_valid = 1'b0;
    check("mid_queued", int'(fifo_count), 3);
    tick(51);
    rst_n = 1'b0;
    tick(1);
    check("mid_rst_tx", int'(tx), 1);
    check("mid_rst_count", int'(fifo_count), 0);
    check("mid_rst_busy", int'(tx_busy), 0);
    check("mid_rst_ready", int'(tx_ready), 0);
    rst_n = 1'b1;
    busy_cnt = 0;
    for (int k = 0; k < 300; k++) begin tick(1); if (tx_busy || !tx) busy_cnt++; end
    check("mid_no_more_frames", busy_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
